// File: rtl/cdc_handshake_rx.sv
// cdc_handshake_rx
//   Receive side of a toggle/ack clock-domain-crossing handshake. A change on
//   the (already synchronized) request toggle starts a settle interval, after
//   which the source-held word is captured and offered on a valid/ready port.
//   Acceptance flips the acknowledge toggle back toward the source domain.
//
// Ports
//   clk, rst_n     destination clock, async active-low reset
//   req_tgl_sync   synchronized request toggle
//   data_in        source word, held stable by the source until it sees ack
//   data_ready     downstream accepts data_out this cycle
//   data_out       captured word, held until the next capture
//   data_valid     data_out valid, held until accepted
//   ack_tgl        acknowledge toggle (registered, glitch-free)
//   busy           high while settling or presenting data
//   proto_err      sticky: source toggled again before being acknowledged
//   xfer_cnt       completed-transfer count, wraps at 16 bits
module cdc_handshake_rx #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_tgl_sync,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  ack_tgl,
  output logic                  busy,
  output logic                  proto_err,
  output logic [15:0]           xfer_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    VALID  = 2'd2
  } state_t;

  state_t     state;
  logic       req_prev;
  logic [3:0] cnt;
  logic       evt;

  // req_prev only follows the toggle in IDLE, so an early toggle stays
  // pending and is picked up once the current transfer has been acked.
  assign evt  = req_tgl_sync ^ req_prev;
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_prev   <= 1'b0;
      cnt        <= 4'd0;
      data_out   <= '0;
      data_valid <= 1'b0;
      ack_tgl    <= 1'b0;
      proto_err  <= 1'b0;
      xfer_cnt   <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (evt) begin
            req_prev <= req_tgl_sync;
            cnt      <= 4'(SETTLE_CYCLES);
            state    <= SETTLE;
          end
        end
        SETTLE: begin
          if (evt) proto_err <= 1'b1;
          if (cnt == 4'd0) begin
            data_out   <= data_in;
            data_valid <= 1'b1;
            state      <= VALID;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        VALID: begin
          if (evt) proto_err <= 1'b1;
          if (data_ready) begin
            ack_tgl    <= ~ack_tgl;
            data_valid <= 1'b0;
            xfer_cnt   <= xfer_cnt + 16'd1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cdc_handshake_rx.md
# cdc_handshake_rx

Receive-side controller of a toggle/ack clock-domain-crossing handshake in the TEMAC datapath. It sits directly downstream of the two-flop bit synchronizer: it consumes the already-synchronized request toggle, waits a settle interval, and captures a source-held multi-bit word. It then presents the word on a valid/ready interface and returns an acknowledge toggle to the source domain, where the source domain synchronizes it again. It also flags protocol violations and counts completed transfers.

## Interface
- DATA_WIDTH, 32, width of the transferred word.
- SETTLE_CYCLES, 2, extra cycles between detecting the toggle and sampling data_in (range 0..15).
- clk  input  1  destination-domain clock; all logic on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low; all state cleared while low.
- req_tgl_sync  input  1  request toggle, already passed through the two-flop synchronizer in this domain.
- data_in  input  DATA_WIDTH  source-domain word; the source holds it stable from its req toggle until it sees ack.
- data_ready  input  1  downstream accepts data_out this cycle.
- data_out  output  DATA_WIDTH  captured word; registered; held until the next capture.
- data_valid  output  1  data_out valid; held high until accepted.
- ack_tgl  output  1  acknowledge toggle to the source domain; registered, glitch-free.
- busy  output  1  high in SETTLE or VALID.
- proto_err  output  1  sticky; set when the source toggles again before being acknowledged.
- xfer_cnt  output  16  completed-transfer count; wraps 0xFFFF->0x0000.

## Operation
- Reset values: state IDLE; req_prev=0, ack_tgl=0, data_valid=0, data_out=0, busy=0, proto_err=0, xfer_cnt=0, settle counter=0.
- evt = req_tgl_sync XOR req_prev (combinational).
- IDLE: if evt, then req_prev<=req_tgl_sync, cnt<=SETTLE_CYCLES, and the state goes to SETTLE. Otherwise the state stays in IDLE.
- SETTLE: if cnt==0, then data_out<=data_in, data_valid<=1, and the state goes to VALID. Otherwise cnt<=cnt-1.
- VALID: data_valid is held high. If data_ready, then:
  - ack_tgl<=~ack_tgl,
  - data_valid<=0,
  - xfer_cnt<=xfer_cnt+1,
  - the state goes to IDLE.
- No other transitions. data_out changes only at a capture.
- Protocol error: evt=1 in SETTLE or VALID means the source toggled before ack. proto_err<=1 and stays set until rst_n. req_prev is not updated outside IDLE. The early toggle therefore stays pending and is serviced on return to IDLE. A double early toggle cancels out: the transfer is lost, and only proto_err records it.
- Simultaneous data_ready and early toggle in VALID: the transfer completes normally, proto_err sets on the same edge, and the pending event is accepted in IDLE on the next edge.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous), including ack_tgl=0. The source domain must be reset together with this block. The block does not resynchronize toggle phase on its own.
- busy = (state != IDLE). It is decoded from registered state.

## Timing
- The edge at which evt is first sampled is E0.
  - State SETTLE from E0.
  - Capture at edge E0+SETTLE_CYCLES+1; data_valid is high from then.
  - SETTLE_CYCLES=0 gives capture at E0+1.
- The edge that samples data_valid & data_ready is Ea.
  - data_valid falls at Ea, and ack_tgl and xfer_cnt update at Ea.
  - The earliest next capture is Ea+SETTLE_CYCLES+2 (IDLE at Ea, accept at Ea+1).
- Minimum toggle-to-ack with data_ready tied high: SETTLE_CYCLES+2 edges.
- No combinational path from any input to any output.

## Test plan
- Single transfer: SETTLE_CYCLES=2, data_ready=1. Hold data_in=0xDEADBEEF and toggle req_tgl_sync 0->1. Required: data_valid high exactly 3 edges after E0 with data_out=0xDEADBEEF. data_valid is high for 1 cycle, ack_tgl 0->1, xfer_cnt=1.
- Backpressure: data_ready=0 for 10 cycles after data_valid. Required: data_valid and data_out are stable, ack_tgl is unchanged, and busy=1. Raise data_ready: data_valid falls and ack_tgl toggles on that edge.
- Back-to-back: run 4 transfers 0x1,0x2,0x3,0x4 with alternating toggle polarity, each toggle issued 1 cycle after ack. Required: 4 data_valid pulses in order, ack_tgl ends 0, xfer_cnt=4, proto_err=0.
- Protocol error: toggle req again during SETTLE. Required: proto_err=1 and sticky. The first word is delivered, then the second word is delivered after returning to IDLE, and xfer_cnt=2.
- Reset mid-VALID: drive rst_n low while data_valid=1. Required: data_valid, ack_tgl, xfer_cnt, data_out and proto_err go to 0 asynchronously before the next clk edge, and the state is IDLE after release.
- Wrap: preload by 65536 transfers, or force xfer_cnt=0xFFFF and complete one transfer. Required: xfer_cnt=0x0000, with no effect on other outputs.
